// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS control: FETCH/DECODE/EXEC/MEM/WB sequencing, ihit/dhit stalls, optional memory timeout.
// `define OVERFLOW_TRAP_EN to trap signed overflow of ADD/SUB/ADDI at write-back (sets exc, halts).
module multicycle_control_fsm #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 0
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             overflow,
  input  logic             ihit,
  input  logic             dhit,
  output logic             iREN,
  output logic             dREN,
  output logic             dWEN,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic [1:0]       PCSrc,
  output logic             RegWrite,
  output logic [1:0]       RegDst,
  output logic [1:0]       MemToReg,
  output logic [1:0]       ALUSrc,
  output logic             ExtOp,
  output logic [3:0]       alu_op,
  output logic             halt,
  output logic             mem_err,
  output logic             exc,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03,
                         OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08,
                         OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B,
                         OP_ANDI  = 6'h0C, OP_ORI  = 6'h0D, OP_XORI = 6'h0E,
                         OP_LUI   = 6'h0F, OP_LW   = 6'h23, OP_SW   = 6'h2B,
                         OP_HALT  = 6'h3F;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL  = 6'h02, F_JR  = 6'h08,
                         F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22,
                         F_SUBU = 6'h23, F_AND = 6'h24, F_OR  = 6'h25,
                         F_XOR = 6'h26, F_NOR  = 6'h27, F_SLT = 6'h2A,
                         F_SLTU = 6'h2B;
  localparam logic [3:0] ALU_SLL = 4'd0, ALU_SRL = 4'd1, ALU_ADD = 4'd2,
                         ALU_SUB = 4'd3, ALU_AND = 4'd4, ALU_OR  = 4'd5,
                         ALU_XOR = 4'd6, ALU_NOR = 4'd7, ALU_SLT = 4'd8,
                         ALU_SLTU = 4'd9;

  localparam int WW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam bit            TMO_EN  = (MEM_TIMEOUT != 0);
  localparam logic [WW-1:0] TMO_VAL = WW'(MEM_TIMEOUT);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEMRD, S_MEMWR, S_WB, S_HALTED
  } state_t;

  typedef enum logic [3:0] {
    K_NOP, K_ALU, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL, K_JR, K_HALT
  } kind_t;

  state_t        state, next_state;
  kind_t         kind;
  logic [WW-1:0] wait_cnt;
  logic [1:0]    pc_src_d;
  logic          ov_chk;
  logic          ireq, drd, dwr, irw, pcw, rw;
  logic          pending, hit_now, tmo_now, tmo, count, trap;

  always_comb begin
    kind     = K_NOP;
    RegDst   = 2'd0;
    MemToReg = 2'd1;
    ALUSrc   = 2'd0;
    ExtOp    = 1'b1;
    alu_op   = ALU_ADD;
    pc_src_d = 2'd0;
    ov_chk   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        kind = K_ALU;
        case (funct)
          F_SLL:  begin alu_op = ALU_SLL; ALUSrc = 2'd2; end
          F_SRL:  begin alu_op = ALU_SRL; ALUSrc = 2'd2; end
          F_JR:   begin kind = K_JR; pc_src_d = 2'd3; end
          F_ADD:  begin alu_op = ALU_ADD; ov_chk = 1'b1; end
          F_ADDU: alu_op = ALU_ADD;
          F_SUB:  begin alu_op = ALU_SUB; ov_chk = 1'b1; end
          F_SUBU: alu_op = ALU_SUB;
          F_AND:  alu_op = ALU_AND;
          F_OR:   alu_op = ALU_OR;
          F_XOR:  alu_op = ALU_XOR;
          F_NOR:  alu_op = ALU_NOR;
          F_SLT:  alu_op = ALU_SLT;
          F_SLTU: alu_op = ALU_SLTU;
          default: kind = K_NOP;
        endcase
      end
      OP_J:    begin kind = K_J; pc_src_d = 2'd2; end
      OP_JAL:  begin kind = K_JAL; pc_src_d = 2'd2; RegDst = 2'd2; MemToReg = 2'd2; end
      OP_BEQ:  begin kind = K_BEQ; pc_src_d = 2'd1; alu_op = ALU_SUB; end
      OP_BNE:  begin kind = K_BNE; pc_src_d = 2'd1; alu_op = ALU_SUB; end
      OP_ADDI: begin kind = K_ALU; RegDst = 2'd1; ALUSrc = 2'd1; ov_chk = 1'b1; end
      OP_ADDIU: begin kind = K_ALU; RegDst = 2'd1; ALUSrc = 2'd1; end
      OP_SLTI: begin kind = K_ALU; RegDst = 2'd1; ALUSrc = 2'd1; alu_op = ALU_SLT; end
      OP_SLTIU: begin kind = K_ALU; RegDst = 2'd1; ALUSrc = 2'd1; alu_op = ALU_SLTU; end
      OP_ANDI: begin kind = K_ALU; RegDst = 2'd1; ALUSrc = 2'd1; ExtOp = 1'b0; alu_op = ALU_AND; end
      OP_ORI:  begin kind = K_ALU; RegDst = 2'd1; ALUSrc = 2'd1; ExtOp = 1'b0; alu_op = ALU_OR; end
      OP_XORI: begin kind = K_ALU; RegDst = 2'd1; ALUSrc = 2'd1; ExtOp = 1'b0; alu_op = ALU_XOR; end
      OP_LUI:  begin kind = K_ALU; RegDst = 2'd1; ALUSrc = 2'd1; ExtOp = 1'b0; MemToReg = 2'd3; end
      OP_LW:   begin kind = K_LW; RegDst = 2'd1; ALUSrc = 2'd1; MemToReg = 2'd0; end
      OP_SW:   begin kind = K_SW; ALUSrc = 2'd1; end
      OP_HALT: kind = K_HALT;
      default: kind = K_NOP;
    endcase
  end

`ifdef OVERFLOW_TRAP_EN
  logic ov_q, exc_q;
  assign exc = exc_q;
`else
  logic unused_overflow;
  assign unused_overflow = overflow;
  assign exc = 1'b0;
`endif

  // Only the hit belonging to the current access is honoured.
  assign pending = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  assign hit_now = (state == S_FETCH) ? ihit : (pending && dhit);
  assign tmo_now = TMO_EN && pending && !hit_now && (wait_cnt == TMO_VAL);

  always_comb begin
    next_state = state;
    ireq  = 1'b0;
    drd   = 1'b0;
    dwr   = 1'b0;
    irw   = 1'b0;
    pcw   = 1'b0;
    rw    = 1'b0;
    tmo   = 1'b0;
    count = 1'b0;
    trap  = 1'b0;
    case (state)
      S_FETCH: begin
        ireq = 1'b1;
        if (ihit) begin
          irw = 1'b1;
          pcw = 1'b1;
          next_state = S_DECODE;
        end else if (tmo_now) begin
          tmo = 1'b1;
          next_state = S_HALTED;
        end
      end
      S_DECODE: next_state = (kind == K_HALT) ? S_HALTED : S_EXEC;
      S_EXEC: begin
        next_state = S_FETCH;
        count = 1'b1;
        case (kind)
          K_BEQ: pcw = zero;
          K_BNE: pcw = !zero;
          K_J, K_JR: pcw = 1'b1;
          K_JAL: begin pcw = 1'b1; rw = 1'b1; end
          K_LW:  begin next_state = S_MEMRD; count = 1'b0; end
          K_SW:  begin next_state = S_MEMWR; count = 1'b0; end
          K_ALU: begin next_state = S_WB; count = 1'b0; end
          default: ;
        endcase
      end
      S_MEMRD: begin
        drd = 1'b1;
        if (dhit) next_state = S_WB;
        else if (tmo_now) begin tmo = 1'b1; next_state = S_HALTED; end
      end
      S_MEMWR: begin
        dwr = 1'b1;
        if (dhit) begin next_state = S_FETCH; count = 1'b1; end
        else if (tmo_now) begin tmo = 1'b1; next_state = S_HALTED; end
      end
      S_WB: begin
        rw = 1'b1;
        next_state = S_FETCH;
        count = 1'b1;
`ifdef OVERFLOW_TRAP_EN
        if (ov_chk && ov_q) begin
          rw = 1'b0;
          trap = 1'b1;
          count = 1'b0;
          next_state = S_HALTED;
        end
`endif
      end
      S_HALTED: ;
      default: next_state = S_FETCH;
    endcase
  end

  // Strobes are gated by reset so an in-flight access is dropped at the reset edge.
  assign iREN     = ireq & nRST;
  assign dREN     = drd & nRST;
  assign dWEN     = dwr & nRST;
  assign IRWrite  = irw & nRST;
  assign PCWrite  = pcw & nRST;
  assign RegWrite = rw & nRST;
  assign PCSrc    = (state == S_EXEC) ? pc_src_d : 2'd0;
  assign halt     = (state == S_HALTED);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= S_FETCH;
      wait_cnt  <= '0;
      instr_cnt <= '0;
      mem_err   <= 1'b0;
    end else begin
      state <= next_state;
      if (pending && !hit_now && !tmo_now) wait_cnt <= wait_cnt + 1'b1;
      else                                 wait_cnt <= '0;
      if (count) instr_cnt <= instr_cnt + 1'b1;
      if (tmo)   mem_err   <= 1'b1;
    end
  end

`ifdef OVERFLOW_TRAP_EN
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      ov_q  <= 1'b0;
      exc_q <= 1'b0;
    end else begin
      if (state == S_EXEC) ov_q <= overflow;
      if (trap) exc_q <= 1'b1;
    end
  end
`else
  logic unused_trap;
  assign unused_trap = trap ^ ov_chk;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench for multicycle_control_fsm against an instruction-level phase model.
module tb_multicycle_control_fsm;
  localparam int CNT_W = 8;
  localparam int TMO   = 4;

  logic CLK = 1'b0, nRST = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic zero = 1'b0, overflow = 1'b0, ihit = 1'b0, dhit = 1'b0;
  logic iREN, dREN, dWEN, IRWrite, PCWrite, RegWrite, halt, mem_err, exc, ExtOp;
  logic [1:0] PCSrc, RegDst, MemToReg, ALUSrc;
  logic [3:0] alu_op;
  logic [CNT_W-1:0] instr_cnt;

  multicycle_control_fsm #(.CNT_W(CNT_W), .MEM_TIMEOUT(TMO)) dut (
    .CLK(CLK), .nRST(nRST), .opcode(opcode), .funct(funct), .zero(zero),
    .overflow(overflow), .ihit(ihit), .dhit(dhit), .iREN(iREN), .dREN(dREN),
    .dWEN(dWEN), .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc),
    .RegWrite(RegWrite), .RegDst(RegDst), .MemToReg(MemToReg), .ALUSrc(ALUSrc),
    .ExtOp(ExtOp), .alu_op(alu_op), .halt(halt), .mem_err(mem_err), .exc(exc),
    .instr_cnt(instr_cnt)
  );

  always #5 CLK = ~CLK;

  // Class codes for the phase model.
  localparam int C_ALU = 0, C_LW = 1, C_SW = 2, C_BEQ = 3, C_BNE = 4,
                 C_J = 5, C_JAL = 6, C_JR = 7, C_NOP = 8, C_HALT = 9;
  // {halt, iREN, dREN, dWEN, IRWrite, PCWrite, RegWrite}
  localparam logic [6:0] V_HALT = 7'h40, V_IREN = 7'h20, V_DREN = 7'h10,
                         V_DWEN = 7'h08, V_IRW = 7'h04, V_PCW = 7'h02, V_RW = 7'h01;

  typedef struct {
    logic [5:0] op, fn;
    int cls;
    logic [3:0] aop;
    logic [1:0] asrc;
    logic ext;
    logic [1:0] rdst, m2r;
    bit ovchk, chk_alu, chk_ext;
  } ins_t;

  ins_t tab[$];
  wire [6:0] vec = {halt, iREN, dREN, dWEN, IRWrite, PCWrite, RegWrite};

  int n_tests = 0, n_fail = 0;
  int exp_cnt;
  bit exp_memerr, exp_exc, m_halted;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic add(input logic [5:0] op, input logic [5:0] fn, input int cls,
                     input logic [3:0] aop, input logic [1:0] asrc, input logic ext,
                     input logic [1:0] rdst, input logic [1:0] m2r, input bit ovchk,
                     input bit chk_alu, input bit chk_ext);
    ins_t t;
    t.op = op; t.fn = fn; t.cls = cls; t.aop = aop; t.asrc = asrc; t.ext = ext;
    t.rdst = rdst; t.m2r = m2r; t.ovchk = ovchk; t.chk_alu = chk_alu; t.chk_ext = chk_ext;
    tab.push_back(t);
  endtask

  function automatic int find(input logic [5:0] op, input logic [5:0] fn);
    foreach (tab[i]) if (tab[i].op == op && (op != 6'h00 || tab[i].fn == fn)) return i;
    return 0;
  endfunction

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic halted_cycles(input int n);
    m_halted = 1;
    for (int i = 0; i < n; i++) begin
      ihit = 1'($urandom); dhit = 1'($urandom); opcode = 6'($urandom);
      #1;
      check("halted", 32'(vec), 32'(V_HALT));
      check("mem_err", 32'(mem_err), 32'(exp_memerr));
      check("exc", 32'(exc), 32'(exp_exc));
      next_cycle();
    end
  endtask

  task automatic do_reset(input bit force_hits);
    nRST = 1'b0;
    ihit = force_hits ? 1'b1 : 1'($urandom);
    dhit = force_hits ? 1'b1 : 1'($urandom);
    #1;
    check("rst_strobes", 32'(vec[5:0]), 32'd0);
    next_cycle();
    nRST = 1'b1; ihit = 1'b0; dhit = 1'b0;
    exp_cnt = 0; exp_memerr = 0; exp_exc = 0; m_halted = 0;
    check("rst_flags", {29'd0, halt, mem_err, exc}, 32'd0);
    check("rst_cnt", 32'(instr_cnt), 32'd0);
  endtask

  task automatic run_instr(input int idx, input int iwait, input int dwait,
                           input bit z, input bit ov, input bit abort);
    ins_t t;
    logic [6:0] e;
    bit hit, trap;
    t = tab[idx];
    opcode = t.op; funct = t.fn;
    check("cnt", 32'(instr_cnt), 32'(exp_cnt % (1 << CNT_W)));
    for (int c = 0; c <= TMO; c++) begin
      hit = (c == iwait);
      ihit = hit; dhit = 1'($urandom); zero = 1'($urandom); overflow = 1'($urandom);
      #1;
      check("fetch", 32'(vec), 32'(hit ? (V_IREN | V_IRW | V_PCW) : V_IREN));
      if (hit) check("fetch_pcsrc", 32'(PCSrc), 32'd0);
      next_cycle();
      if (hit) break;
    end
    ihit = 1'b0;
    if (iwait > TMO) begin exp_memerr = 1; halted_cycles(2); return; end
    dhit = 1'($urandom);
    #1;
    check("decode", 32'(vec), 32'd0);
    next_cycle();
    if (t.cls == C_HALT) begin halted_cycles(2); return; end
    zero = z; overflow = ov; ihit = 1'($urandom); dhit = 1'($urandom);
    #1;
    e = 7'd0;
    case (t.cls)
      C_BEQ: if (z) e = V_PCW;
      C_BNE: if (!z) e = V_PCW;
      C_J, C_JR: e = V_PCW;
      C_JAL: e = V_PCW | V_RW;
      default: ;
    endcase
    check("exec", 32'(vec), 32'(e));
    if (e & V_PCW)
      check("exec_pcsrc", 32'(PCSrc),
            (t.cls == C_JR) ? 32'd3 : (t.cls == C_J || t.cls == C_JAL) ? 32'd2 : 32'd1);
    if (t.cls == C_JAL) check("jal_sel", {28'd0, RegDst, MemToReg}, 32'b1010);
    if (t.cls <= C_BNE) begin
      if (t.chk_alu) check("alu_op", 32'(alu_op), 32'(t.aop));
      check("alusrc", 32'(ALUSrc), 32'(t.asrc));
      if (t.chk_ext) check("extop", 32'(ExtOp), 32'(t.ext));
    end
    next_cycle();
    zero = 1'b0; overflow = 1'($urandom); ihit = 1'b0;
    if (t.cls >= C_BEQ) begin exp_cnt++; return; end
    if (t.cls == C_LW || t.cls == C_SW) begin
      for (int c = 0; c <= TMO; c++) begin
        if (abort && c == 0) begin do_reset(1); return; end
        hit = (c == dwait);
        dhit = hit; ihit = 1'($urandom);
        #1;
        check("mem", 32'(vec), 32'((t.cls == C_LW) ? V_DREN : V_DWEN));
        next_cycle();
        if (hit) break;
      end
      dhit = 1'b0; ihit = 1'b0;
      if (dwait > TMO) begin exp_memerr = 1; halted_cycles(2); return; end
      if (t.cls == C_SW) begin exp_cnt++; return; end
    end
    ihit = 1'($urandom); dhit = 1'($urandom);
    #1;
    trap = 0;
`ifdef OVERFLOW_TRAP_EN
    trap = t.ovchk && ov;
`endif
    check("wb", 32'(vec), trap ? 32'd0 : 32'(V_RW));
    if (!trap) check("wb_sel", {28'd0, RegDst, MemToReg}, {28'd0, t.rdst, t.m2r});
    next_cycle();
    ihit = 1'b0; dhit = 1'b0;
    if (trap) begin exp_exc = 1; halted_cycles(2); return; end
    exp_cnt++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, iw, dw;
    add(6'h00, 6'h00, C_ALU, 4'd0, 2'd2, 1'b0, 2'd0, 2'd1, 0, 1, 0);
    add(6'h00, 6'h02, C_ALU, 4'd1, 2'd2, 1'b0, 2'd0, 2'd1, 0, 1, 0);
    add(6'h00, 6'h20, C_ALU, 4'd2, 2'd0, 1'b0, 2'd0, 2'd1, 1, 1, 0);
    add(6'h00, 6'h21, C_ALU, 4'd2, 2'd0, 1'b0, 2'd0, 2'd1, 0, 1, 0);
    add(6'h00, 6'h22, C_ALU, 4'd3, 2'd0, 1'b0, 2'd0, 2'd1, 1, 1, 0);
    add(6'h00, 6'h23, C_ALU, 4'd3, 2'd0, 1'b0, 2'd0, 2'd1, 0, 1, 0);
    add(6'h00, 6'h24, C_ALU, 4'd4, 2'd0, 1'b0, 2'd0, 2'd1, 0, 1, 0);
    add(6'h00, 6'h25, C_ALU, 4'd5, 2'd0, 1'b0, 2'd0, 2'd1, 0, 1, 0);
    add(6'h00, 6'h26, C_ALU, 4'd6, 2'd0, 1'b0, 2'd0, 2'd1, 0, 1, 0);
    add(6'h00, 6'h27, C_ALU, 4'd7, 2'd0, 1'b0, 2'd0, 2'd1, 0, 1, 0);
    add(6'h00, 6'h2A, C_ALU, 4'd8, 2'd0, 1'b0, 2'd0, 2'd1, 0, 1, 0);
    add(6'h00, 6'h2B, C_ALU, 4'd9, 2'd0, 1'b0, 2'd0, 2'd1, 0, 1, 0);
    add(6'h00, 6'h08, C_JR,  4'd0, 2'd0, 1'b0, 2'd0, 2'd0, 0, 0, 0);
    add(6'h00, 6'h3F, C_NOP, 4'd0, 2'd0, 1'b0, 2'd0, 2'd0, 0, 0, 0);
    add(6'h08, 6'h00, C_ALU, 4'd2, 2'd1, 1'b1, 2'd1, 2'd1, 1, 1, 1);
    add(6'h09, 6'h00, C_ALU, 4'd2, 2'd1, 1'b1, 2'd1, 2'd1, 0, 1, 1);
    add(6'h0A, 6'h00, C_ALU, 4'd8, 2'd1, 1'b1, 2'd1, 2'd1, 0, 1, 1);
    add(6'h0B, 6'h00, C_ALU, 4'd9, 2'd1, 1'b1, 2'd1, 2'd1, 0, 1, 1);
    add(6'h0C, 6'h00, C_ALU, 4'd4, 2'd1, 1'b0, 2'd1, 2'd1, 0, 1, 1);
    add(6'h0D, 6'h00, C_ALU, 4'd5, 2'd1, 1'b0, 2'd1, 2'd1, 0, 1, 1);
    add(6'h0E, 6'h00, C_ALU, 4'd6, 2'd1, 1'b0, 2'd1, 2'd1, 0, 1, 1);
    add(6'h0F, 6'h00, C_ALU, 4'd0, 2'd1, 1'b0, 2'd1, 2'd3, 0, 0, 1);
    add(6'h23, 6'h00, C_LW,  4'd2, 2'd1, 1'b1, 2'd1, 2'd0, 0, 1, 1);
    add(6'h2B, 6'h00, C_SW,  4'd2, 2'd1, 1'b1, 2'd0, 2'd0, 0, 1, 1);
    add(6'h04, 6'h00, C_BEQ, 4'd3, 2'd0, 1'b0, 2'd0, 2'd0, 0, 1, 0);
    add(6'h05, 6'h00, C_BNE, 4'd3, 2'd0, 1'b0, 2'd0, 2'd0, 0, 1, 0);
    add(6'h02, 6'h00, C_J,   4'd0, 2'd0, 1'b0, 2'd0, 2'd0, 0, 0, 0);
    add(6'h03, 6'h00, C_JAL, 4'd0, 2'd0, 1'b0, 2'd2, 2'd2, 0, 0, 0);
    add(6'h3E, 6'h00, C_NOP, 4'd0, 2'd0, 1'b0, 2'd0, 2'd0, 0, 0, 0);
    add(6'h24, 6'h00, C_NOP, 4'd0, 2'd0, 1'b0, 2'd0, 2'd0, 0, 0, 0);
    add(6'h3F, 6'h00, C_HALT, 4'd0, 2'd0, 1'b0, 2'd0, 2'd0, 0, 0, 0);

    #1;
    do_reset(0);
    run_instr(find(6'h00, 6'h21), 0, 0, 0, 0, 0);   // ADDU, immediate ihit
    run_instr(find(6'h23, 6'h00), 1, 3, 0, 0, 0);   // LW, dhit delayed 3
    run_instr(find(6'h04, 6'h00), 0, 0, 1, 0, 0);   // BEQ taken
    run_instr(find(6'h05, 6'h00), 0, 0, 1, 0, 0);   // BNE not taken
    run_instr(find(6'h2B, 6'h00), TMO, TMO, 0, 0, 0); // hits in the timeout cycle win
    run_instr(find(6'h00, 6'h21), 99, 0, 0, 0, 0);  // fetch timeout
    do_reset(0);
    run_instr(find(6'h23, 6'h00), 0, 99, 0, 0, 0);  // data timeout
    do_reset(0);
    run_instr(find(6'h00, 6'h20), 0, 0, 0, 1, 0);   // ADD with overflow
    if (m_halted) do_reset(0);
    run_instr(find(6'h2B, 6'h00), 0, 0, 0, 0, 1);   // reset during store
    run_instr(find(6'h3F, 6'h00), 0, 0, 0, 0, 0);   // HALT
    do_reset(0);
    for (int i = 0; i < (1 << CNT_W) + 4; i++)       // counter wrap
      run_instr(find(6'h04, 6'h00), 0, 0, 1'($urandom), 0, 0);
    for (int i = 0; i < 400; i++) begin
      idx = int'($urandom_range(0, tab.size() - 1));
      iw = ($urandom_range(0, 39) == 0) ? 99 : int'($urandom_range(0, TMO));
      dw = ($urandom_range(0, 19) == 0) ? 99 : int'($urandom_range(0, TMO));
      run_instr(idx, iw, dw, 1'($urandom), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 29) == 0));
      if (m_halted) do_reset(0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
